l1_rd_port_gated: RTL and testbench

Per-port read-address generator for the multi-stream buffer L1, generalising the single-port read path with non-power-of-two stream depth, pointer wrap-around, stream-init gating, per-stream occupancy protection and a registered address output. Port `portid` receives a stream id, forks it into a one-hot request to the L1 control transpose and into a BRAM read address. The address is offset by the number of same-stream reads issued in the same cycle by lower-numbered ports. It sits between the read-port arbiter and the L1 BRAM; one instance exists per port.

---
 rtl/l1_pkg.sv | 24 ++
 rtl/l1_rd_ptr_calc.sv | 56 +++++
 rtl/l1_rd_port_gated.sv | 151 +++++++++++++++
 tb/tb_l1_rd_port_gated.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_pkg.sv
// Shared definitions for the L1 read/write port address generators:
// drop-mode constants and the wrap-around pointer add.
package l1_pkg;

    // Behaviour when a request targets a stream that has not been initialised.
    localparam int DROP_UNINIT_STALL = 0;
    localparam int DROP_UNINIT_DROP  = 1;

    // Adds inc to ptr and folds the result back into 0..depth-1.
    // Only a single subtract is needed because ptr < depth and inc < depth.
    function automatic logic [31:0] f_wrap_add(
        input logic [31:0] ptr,
        input logic [31:0] inc,
        input logic [31:0] depth
    );
        logic [31:0] sum;
        sum = ptr + inc;
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return sum;
    endfunction

endpackage

// File: rtl/l1_rd_ptr_calc.sv
// Combinational pointer calculation for one L1 port: counts same-stream
// requests from lower-numbered ports, checks the stream can supply that
// many entries, and produces the wrapped entry index.
module l1_rd_ptr_calc
    import l1_pkg::*;
#(
    parameter int nstrms    = 64,
    parameter int sid_width = $clog2(nstrms),
    parameter int nports    = 8,
    parameter int portid    = 0,
    parameter int depth     = 48,
    parameter int ptr_width = $clog2(depth),
    parameter int cnt_width = $clog2(depth + 1)
) (
    input  logic [sid_width-1:0]        sid,
    input  logic [nports-1:0]           cmp_v,
    input  logic [nports*sid_width-1:0] cmp_sid,
    input  logic [nstrms*ptr_width-1:0] ptrs,
    input  logic [nstrms*cnt_width-1:0] cnts,
    input  logic [nstrms-1:0]           init,
    output logic                        stream_init,
    output logic                        eligible,
    output logic [ptr_width-1:0]        ptr
);

    localparam int HIT_W = $clog2(nports) + 1;

    logic [nports-1:0]    match;
    logic [HIT_W-1:0]     hits;
    logic [ptr_width-1:0] cur_ptr;
    logic [cnt_width-1:0] cur_cnt;

    // Only ports with a lower index than this one claim entries ahead of us.
    genvar gi;
    generate
        for (gi = 0; gi < nports; gi++) begin : g_match
            localparam bit BELOW = (gi < portid);
            assign match[gi] = BELOW & cmp_v[gi]
                             & (cmp_sid[gi*sid_width +: sid_width] == sid);
        end
    endgenerate

    // Popcount of earlier same-stream reads, then eligibility and wrapped address.
    always_comb begin
        hits = '0;
        for (int i = 0; i < nports; i++) begin
            hits = hits + HIT_W'(match[i]);
        end
        cur_ptr     = ptrs[sid*ptr_width +: ptr_width];
        cur_cnt     = cnts[sid*cnt_width +: cnt_width];
        stream_init = init[sid];
        eligible    = stream_init & (32'(hits) < 32'(cur_cnt));
        ptr         = ptr_width'(f_wrap_add(32'(cur_ptr), 32'(hits), 32'(depth)));
    end

endmodule

// File: rtl/l1_rd_port_gated.sv
// Per-port L1 read-address generator. S1 holds the incoming stream id and
// forks it into a one-hot request to the control transpose and an address
// into the S2 output register; each branch completes independently.
module l1_rd_port_gated
    import l1_pkg::*;
#(
    parameter int nstrms      = 64,
    parameter int sid_width   = $clog2(nstrms),
    parameter int nports      = 8,
    parameter int portid      = 0,
    parameter int depth       = 48,
    parameter int ptr_width   = $clog2(depth),
    parameter int cnt_width   = $clog2(depth + 1),
    parameter int drop_uninit = DROP_UNINIT_STALL
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        i_rd_v,
    output logic                        i_rd_r,
    input  logic [sid_width-1:0]        i_rd_sid,
    input  logic [nports-1:0]           i_cmp_sid_v,
    input  logic [nports*sid_width-1:0] i_cmp_sid_d,
    input  logic [nstrms*ptr_width-1:0] i_ptrs,
    input  logic [nstrms*cnt_width-1:0] i_cnts,
    input  logic [nstrms-1:0]           i_init,
    output logic [nstrms-1:0]           o_req_v,
    input  logic [nstrms-1:0]           o_req_r,
    output logic                        o_addr_v,
    input  logic                        o_addr_r,
    output logic [ptr_width-1:0]        o_addr_ptr,
    output logic [sid_width-1:0]        o_addr_sid,
    output logic                        o_err_v,
    output logic [sid_width-1:0]        o_err_sid
);

    // Hits never exceed nports-1, so the single wrap subtract is enough.
    generate
        if ((nports > depth) || (depth < 2) || (portid >= nports)) begin : g_param_check
            $error("l1_rd_port_gated: need 2 <= depth, nports <= depth, portid < nports");
        end
    endgenerate

    logic                        s1_v_q, s1_v_d;
    logic [sid_width-1:0]        s1_sid_q, s1_sid_d;
    logic [nports-1:0]           cmp_v_q, cmp_v_d;
    logic [nports*sid_width-1:0] cmp_sid_q, cmp_sid_d;
    logic                        req_done_q, req_done_d;
    logic                        addr_done_q, addr_done_d;
    logic                        s2_v_q, s2_v_d;
    logic [ptr_width-1:0]        s2_ptr_q, s2_ptr_d;
    logic [sid_width-1:0]        s2_sid_q, s2_sid_d;

    logic                        stream_init;
    logic                        eligible;
    logic [ptr_width-1:0]        calc_ptr;
    logic                        s1_go, s1_drop, s1_retire;
    logic                        req_fire, addr_fire, s2_free;
    logic [nstrms-1:0]           sid_onehot;

    l1_rd_ptr_calc #(
        .nstrms    (nstrms),
        .sid_width (sid_width),
        .nports    (nports),
        .portid    (portid),
        .depth     (depth),
        .ptr_width (ptr_width),
        .cnt_width (cnt_width)
    ) u_calc (
        .sid         (s1_sid_q),
        .cmp_v       (cmp_v_q),
        .cmp_sid     (cmp_sid_q),
        .ptrs        (i_ptrs),
        .cnts        (i_cnts),
        .init        (i_init),
        .stream_init (stream_init),
        .eligible    (eligible),
        .ptr         (calc_ptr)
    );

    // Fork control: once either branch has completed the entry is committed
    // and finishes even if eligibility changes underneath it.
    always_comb begin
        s1_go       = s1_v_q & (eligible | req_done_q | addr_done_q);
        s1_drop     = s1_v_q & ~stream_init & ~req_done_q & ~addr_done_q
                    & (drop_uninit == DROP_UNINIT_DROP);
        sid_onehot  = '0;
        sid_onehot[s1_sid_q] = 1'b1;
        req_fire    = s1_go & ~req_done_q & o_req_r[s1_sid_q];
        s2_free     = ~s2_v_q | o_addr_r;
        addr_fire   = s1_go & ~addr_done_q & s2_free;
        s1_retire   = s1_drop
                    | (s1_go & (req_done_q | req_fire) & (addr_done_q | addr_fire));
        i_rd_r      = ~s1_v_q | s1_retire;
        o_req_v     = (s1_go & ~req_done_q) ? sid_onehot : '0;
        o_addr_v    = s2_v_q;
        o_addr_ptr  = s2_ptr_q;
        o_addr_sid  = s2_sid_q;
        o_err_v     = s1_drop;
        o_err_sid   = s1_drop ? s1_sid_q : '0;
    end

    // Next-state for S1, done flags, the delayed compare bus and S2.
    always_comb begin
        s1_v_d      = s1_v_q;
        s1_sid_d    = s1_sid_q;
        cmp_v_d     = i_cmp_sid_v;
        cmp_sid_d   = i_cmp_sid_d;
        req_done_d  = s1_retire ? 1'b0 : (req_done_q | req_fire);
        addr_done_d = s1_retire ? 1'b0 : (addr_done_q | addr_fire);
        s2_v_d      = s2_v_q;
        s2_ptr_d    = s2_ptr_q;
        s2_sid_d    = s2_sid_q;
        if (i_rd_r) begin
            s1_v_d   = i_rd_v;
            s1_sid_d = i_rd_sid;
        end
        if (addr_fire) begin
            s2_v_d   = 1'b1;
            s2_ptr_d = calc_ptr;
            s2_sid_d = s1_sid_q;
        end else if (o_addr_r) begin
            s2_v_d   = 1'b0;
        end
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v_q      <= 1'b0;
            s1_sid_q    <= '0;
            cmp_v_q     <= '0;
            cmp_sid_q   <= '0;
            req_done_q  <= 1'b0;
            addr_done_q <= 1'b0;
            s2_v_q      <= 1'b0;
            s2_ptr_q    <= '0;
            s2_sid_q    <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_sid_q    <= s1_sid_d;
            cmp_v_q     <= cmp_v_d;
            cmp_sid_q   <= cmp_sid_d;
            req_done_q  <= req_done_d;
            addr_done_q <= addr_done_d;
            s2_v_q      <= s2_v_d;
            s2_ptr_q    <= s2_ptr_d;
            s2_sid_q    <= s2_sid_d;
        end
    end

endmodule

// File: tb/tb_l1_rd_port_gated.sv
// Bench for l1_rd_port_gated: a port-3 dropping instance checked through a
// scoreboard, plus a port-0 stalling instance checked with direct compares.
`timescale 1ns/1ps
module tb_l1_rd_port_gated;

    localparam int NSTRMS = 64;
    localparam int SW     = 6;
    localparam int NPORTS = 8;
    localparam int DEPTH  = 48;
    localparam int PW     = 6;
    localparam int CW     = 6;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // shared stream state
    logic [NPORTS-1:0]    cmp_v;
    logic [NPORTS*SW-1:0] cmp_sid;
    logic [NSTRMS*PW-1:0] ptrs;
    logic [NSTRMS*CW-1:0] cnts;
    logic [NSTRMS-1:0]    init;

    // main instance: portid 3, drop mode
    logic              i_rd_v, i_rd_r;
    logic [SW-1:0]     i_rd_sid;
    logic [NSTRMS-1:0] o_req_v, o_req_r;
    logic              o_addr_v, o_addr_r;
    logic [PW-1:0]     o_addr_ptr;
    logic [SW-1:0]     o_addr_sid;
    logic              o_err_v;
    logic [SW-1:0]     o_err_sid;

    // second instance: portid 0, stall mode
    logic              i_rd_v0, i_rd_r0;
    logic [SW-1:0]     i_rd_sid0;
    logic [NSTRMS-1:0] o_req_v0, o_req_r0;
    logic              o_addr_v0, o_addr_r0;
    logic [PW-1:0]     o_addr_ptr0;
    logic [SW-1:0]     o_addr_sid0;
    logic              o_err_v0;
    logic [SW-1:0]     o_err_sid0;

    l1_rd_port_gated #(.nstrms(NSTRMS), .nports(NPORTS), .portid(3), .depth(DEPTH),
                       .drop_uninit(1)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .i_rd_v(i_rd_v), .i_rd_r(i_rd_r), .i_rd_sid(i_rd_sid),
        .i_cmp_sid_v(cmp_v), .i_cmp_sid_d(cmp_sid),
        .i_ptrs(ptrs), .i_cnts(cnts), .i_init(init),
        .o_req_v(o_req_v), .o_req_r(o_req_r),
        .o_addr_v(o_addr_v), .o_addr_r(o_addr_r),
        .o_addr_ptr(o_addr_ptr), .o_addr_sid(o_addr_sid),
        .o_err_v(o_err_v), .o_err_sid(o_err_sid)
    );

    l1_rd_port_gated #(.nstrms(NSTRMS), .nports(NPORTS), .portid(0), .depth(DEPTH),
                       .drop_uninit(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .i_rd_v(i_rd_v0), .i_rd_r(i_rd_r0), .i_rd_sid(i_rd_sid0),
        .i_cmp_sid_v(cmp_v), .i_cmp_sid_d(cmp_sid),
        .i_ptrs(ptrs), .i_cnts(cnts), .i_init(init),
        .o_req_v(o_req_v0), .o_req_r(o_req_r0),
        .o_addr_v(o_addr_v0), .o_addr_r(o_addr_r0),
        .o_addr_ptr(o_addr_ptr0), .o_addr_sid(o_addr_sid0),
        .o_err_v(o_err_v0), .o_err_sid(o_err_sid0)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { int ptr; int sid; } addr_t;
    int    exp_req[$];
    addr_t exp_addr[$];
    int    exp_err[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h (t=%0t)", name, act, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ptr(input int sid, input int v);
        ptrs[sid*PW +: PW] = PW'(v);
    endtask

    task automatic set_cnt(input int sid, input int v);
        cnts[sid*CW +: CW] = CW'(v);
    endtask

    task automatic set_cmp(input int port, input int sid);
        cmp_v[port] = 1'b1;
        cmp_sid[port*SW +: SW] = SW'(sid);
    endtask

    task automatic push_ok(input int sid, input int ptr);
        addr_t a;
        a.ptr = ptr;
        a.sid = sid;
        exp_req.push_back(sid);
        exp_addr.push_back(a);
    endtask

    // Present a request on the main instance and hold it until accepted.
    task automatic issue(input int sid);
        int n;
        n = 0;
        i_rd_v   = 1'b1;
        i_rd_sid = SW'(sid);
        @(negedge clk);
        while (!i_rd_r && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!i_rd_r) chk("issue_timeout", 64'(i_rd_r), 64'd1);
        tick();
        i_rd_v = 1'b0;
    endtask

    // Monitor: pop and compare on every handshake of the main instance.
    initial begin
        logic          hold_prev;
        logic [PW-1:0] hold_ptr;
        logic [SW-1:0] hold_sid;
        int            e;
        addr_t         a;
        hold_prev = 1'b0;
        hold_ptr  = '0;
        hold_sid  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("addr_hold_v", 64'(o_addr_v), 64'd1);
                    chk("addr_hold_ptr", 64'(o_addr_ptr), 64'(hold_ptr));
                    chk("addr_hold_sid", 64'(o_addr_sid), 64'(hold_sid));
                end
                if ((o_req_v & o_req_r) != '0) begin
                    if (exp_req.size() == 0) begin
                        chk("req_unexpected", o_req_v, 64'd0);
                    end else begin
                        e = exp_req.pop_front();
                        chk("req_onehot", o_req_v, 64'd1 << e);
                    end
                end
                if (o_addr_v && o_addr_r) begin
                    if (exp_addr.size() == 0) begin
                        chk("addr_unexpected", 64'(o_addr_v), 64'd0);
                    end else begin
                        a = exp_addr.pop_front();
                        chk("addr_ptr", 64'(o_addr_ptr), 64'(a.ptr));
                        chk("addr_sid", 64'(o_addr_sid), 64'(a.sid));
                    end
                end
                if (o_err_v) begin
                    if (exp_err.size() == 0) begin
                        chk("err_unexpected", 64'(o_err_v), 64'd0);
                    end else begin
                        e = exp_err.pop_front();
                        chk("err_sid", 64'(o_err_sid), 64'(e));
                    end
                end
                hold_prev = o_addr_v & ~o_addr_r;
                hold_ptr  = o_addr_ptr;
                hold_sid  = o_addr_sid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b1;
        i_rd_v    = 1'b0;
        i_rd_sid  = '0;
        i_rd_v0   = 1'b0;
        i_rd_sid0 = '0;
        o_req_r   = '1;
        o_addr_r  = 1'b1;
        o_req_r0  = '1;
        o_addr_r0 = 1'b1;
        cmp_v     = '0;
        cmp_sid   = '0;
        ptrs      = '0;
        init      = '1;
        init[9]   = 1'b0;
        for (int s = 0; s < NSTRMS; s++) set_cnt(s, 4);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_req_v", o_req_v, 64'd0);
        chk("rst_addr_v", 64'(o_addr_v), 64'd0);
        chk("rst_addr_ptr", 64'(o_addr_ptr), 64'd0);
        chk("rst_addr_sid", 64'(o_addr_sid), 64'd0);
        chk("rst_err_v", 64'(o_err_v), 64'd0);
        chk("rst_err_sid", 64'(o_err_sid), 64'd0);
        chk("rst_rd_r", 64'(i_rd_r), 64'd1);
        chk("rst_rd_r0", 64'(i_rd_r0), 64'd1);
        chk("rst_req_v0", o_req_v0, 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // portid 0: sid 5, ptr 7 -> req at t+1, addr at t+2
        set_ptr(5, 7);
        i_rd_v0 = 1'b1;
        i_rd_sid0 = 6'd5;
        @(negedge clk);
        chk("p0_rd_r", 64'(i_rd_r0), 64'd1);
        tick();
        i_rd_v0 = 1'b0;
        @(negedge clk);
        chk("p0_req_t1", o_req_v0, 64'd1 << 5);
        chk("p0_addr_v_t1", 64'(o_addr_v0), 64'd0);
        @(negedge clk);
        chk("p0_addr_v_t2", 64'(o_addr_v0), 64'd1);
        chk("p0_addr_ptr", 64'(o_addr_ptr0), 64'd7);
        chk("p0_addr_sid", 64'(o_addr_sid0), 64'd5);

        // portid 0, stall mode: uninitialised sid 9 holds until init rises
        set_ptr(9, 20);
        tick();
        i_rd_v0 = 1'b1;
        i_rd_sid0 = 6'd9;
        tick();
        i_rd_v0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("p0_uninit_req", o_req_v0, 64'd0);
            chk("p0_uninit_rd_r", 64'(i_rd_r0), 64'd0);
            chk("p0_uninit_err", 64'(o_err_v0), 64'd0);
        end
        tick();
        init[9] = 1'b1;
        @(negedge clk);
        chk("p0_init_req", o_req_v0, 64'd1 << 9);
        @(negedge clk);
        chk("p0_init_addr_v", 64'(o_addr_v0), 64'd1);
        chk("p0_init_addr_ptr", 64'(o_addr_ptr0), 64'd20);
        tick();
        init[9] = 1'b0;

        // port 3, ports 0 and 2 on sid 5 -> hits 2, 47+2 wraps to 1
        set_ptr(5, 47);
        set_cmp(0, 5);
        set_cmp(2, 5);
        set_cmp(3, 5);
        push_ok(5, 1);
        issue(5);
        cmp_v = '0;
        @(negedge clk);
        chk("p3_req_t1", o_req_v, 64'd1 << 5);
        @(negedge clk);
        chk("p3_addr_v_t2", 64'(o_addr_v), 64'd1);

        // hits 1 (port 2 on another stream): 47+1 wraps to 0
        tick();
        set_cmp(0, 5);
        set_cmp(2, 6);
        push_ok(5, 0);
        issue(5);
        cmp_v = '0;

        // hits 3: ports 0,1,2 count, port 4 is above us and does not
        set_ptr(7, 10);
        set_cmp(0, 7);
        set_cmp(1, 7);
        set_cmp(2, 7);
        set_cmp(4, 7);
        push_ok(7, 13);
        issue(7);
        cmp_v = '0;
        repeat (3) tick();

        // occupancy stall: hits 2 with cnt 2, then cnt raised to 3
        set_cnt(5, 2);
        set_cmp(0, 5);
        set_cmp(2, 5);
        push_ok(5, 1);
        issue(5);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stall_req", o_req_v, 64'd0);
            chk("stall_rd_r", 64'(i_rd_r), 64'd0);
        end
        tick();
        set_cnt(5, 3);
        @(negedge clk);
        chk("unstall_req", o_req_v, 64'd1 << 5);
        tick();
        cmp_v = '0;
        set_cnt(5, 4);
        repeat (2) tick();

        // drop mode: uninitialised sid 9 is dropped with an error pulse
        exp_err.push_back(9);
        issue(9);
        @(negedge clk);
        chk("drop_err_v", 64'(o_err_v), 64'd1);
        chk("drop_req_v", o_req_v, 64'd0);
        chk("drop_addr_v", 64'(o_addr_v), 64'd0);
        @(negedge clk);
        chk("drop_err_pulse", 64'(o_err_v), 64'd0);
        chk("drop_rd_r", 64'(i_rd_r), 64'd1);

        // address back-pressure: request goes out once, S1 waits on S2
        tick();
        set_ptr(5, 7);
        o_addr_r = 1'b0;
        set_cmp(0, 7);
        set_cmp(1, 7);
        set_cmp(2, 7);
        set_cmp(4, 7);
        push_ok(7, 13);
        issue(7);
        cmp_v = '0;
        push_ok(5, 7);
        issue(5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_s1_held", 64'(i_rd_r), 64'd0);
        end
        tick();
        o_addr_r = 1'b1;
        repeat (3) tick();

        // reset while S2 is full and S1 is half done
        o_addr_r = 1'b0;
        set_ptr(6, 3);
        push_ok(5, 7);
        issue(5);
        push_ok(6, 3);
        issue(6);
        @(negedge clk);
        tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req_v", o_req_v, 64'd0);
        chk("mid_rst_addr_v", 64'(o_addr_v), 64'd0);
        chk("mid_rst_addr_ptr", 64'(o_addr_ptr), 64'd0);
        chk("mid_rst_addr_sid", 64'(o_addr_sid), 64'd0);
        chk("mid_rst_err_v", 64'(o_err_v), 64'd0);
        chk("mid_rst_rd_r", 64'(i_rd_r), 64'd1);
        exp_addr.delete();
        tick();
        reset_n = 1'b1;
        o_addr_r = 1'b1;
        tick();
        push_ok(5, 7);
        issue(5);
        @(negedge clk);
        chk("post_rst_req_t1", o_req_v, 64'd1 << 5);
        @(negedge clk);
        chk("post_rst_addr_v", 64'(o_addr_v), 64'd1);
        chk("post_rst_addr_ptr", 64'(o_addr_ptr), 64'd7);
        repeat (5) tick();

        chk("drain_req", 64'(exp_req.size()), 64'd0);
        chk("drain_addr", 64'(exp_addr.size()), 64'd0);
        chk("drain_err", 64'(exp_err.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
